alu_unit: RTL and testbench
===========================

# alu_unit

32-bit registered integer ALU for the ice-risc execute stage. Each rising clock edge it samples two 32-bit operands and a 4-bit operation code, computes one of 16 operations, and registers the 32-bit result with Zero and Sign flags. Downstream writeback and branch logic consume the registered outputs.

## Interface
- No parameters. Data width is fixed at 32 bits and the opcode width at 4 bits.
- clk    in   1   rising-edge clock
- rst    in   1   asynchronous, active-high reset
- A      in   32  operand A
- B      in   32  operand B
- AluOp  in   4   operation select
- Zero   out  1   registered; 1 when X == 0
- Sign   out  1   registered; equals X[31]
- X      out  32  registered result

## Operation
- Shift amount is sh = B[4:0]. Results wrap modulo 2^32. No carry or overflow output.
- AluOp encoding:
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 AND: A&B
  - 3 OR: A|B
  - 4 XOR: A^B
  - 5 NOR: ~(A|B)
  - 6 SLL: A<<sh
  - 7 SRL: A>>sh, zero fill
  - 8 SRA: A>>sh, fill with A[31]
  - 9 SLT: {31'b0, signed(A)<signed(B)}
  - 10 SLTU: {31'b0, A<B unsigned}
  - 11 PASSA: A
  - 12 PASSB: B
  - 13 LUI: {B[15:0],16'h0000}
  - 14 ROR: A rotated right by sh
  - 15 ROL: A rotated left by sh
- Zero and Sign are derived from the same next-state value loaded into X, so all three registers always agree.
- sh = 0: all shifts and rotates return A unchanged.
- B[31:5] is ignored for shifts and rotates.
- SLT/SLTU with A == B give 0. SLT of the most negative value against any larger value gives 1.

## Timing
- Single pipeline stage with one-cycle latency. Inputs present before rising edge N appear on X/Zero/Sign after edge N.
- Outputs hold between edges. Input changes between edges have no effect on the outputs.
- Back-to-back issue: a new operation every cycle, fully pipelined. No handshake and no stall.
- Reset: asserting rst forces X=0, Zero=1, Sign=0 immediately, without waiting for a clock edge. Outputs hold these values while rst is high.
- Release: the first rising edge with rst low loads the computed result.
- Reset mid-stream: the in-flight result is discarded and the reset values apply.

## Test plan
- Reset: assert rst mid-operation with X nonzero -> X=0, Zero=1 and Sign=0 without a clock edge. Release rst with AluOp=0, A=1234, B=5678 -> X=6912 after the next edge.
- Arithmetic:
  - SUB, A=1234, B=5678 -> X=0xFFFFEEA4, Sign=1, Zero=0.
  - SUB, A=1234, B=1234 -> X=0, Zero=1, Sign=0.
  - ADD, 0xFFFFFFFF+1 -> X=0, Zero=1.
- Logic:
  - AND, A=0x82345671, B=0x82345555 -> 0x82345451.
  - NOR, A=0, B=0 -> 0xFFFFFFFF, Sign=1.
- Shifts (A=0x82345671, B=3):
  - SRA -> 0xF0468ACE; SRL -> 0x10468ACE.
  - SLL with A=1234 -> 9872.
  - ROR with A=0x00000001, B=1 -> 0x80000000.
  - B=0x23 uses sh=3.
- Compares:
  - A=0x82345671, B=3: SLT -> 1, SLTU -> 0.
  - A=0x82345671, B=0x83455555: SLT -> 1, SLTU -> 1.
  - A=B: both give 0.
- Sweep: step AluOp 0..15 on consecutive cycles with fixed operands. Each result appears exactly one cycle after its opcode, and LUI with B=0x00001234 gives 0x12340000.

Source files
------------

// File: rtl/alu_unit_if.sv
// -----------------------------------------------------------------------------
// alu_unit_if
// Bundles the operand, opcode and result signals of the ice-risc execute-stage
// ALU. The clock and reset are not part of the bundle; they stay plain ports on
// the ALU itself.
//
// Signals
//    A      32  operand A                       (master -> slave)
//    B      32  operand B                       (master -> slave)
//    AluOp   4  operation select                (master -> slave)
//    X      32  registered result               (slave  -> master)
//    Zero    1  registered, 1 when X == 0       (slave  -> master)
//    Sign    1  registered, equals X[31]        (slave  -> master)
//
// Modports
//    master  the issuing side (decode / testbench)
//    slave   the ALU
// -----------------------------------------------------------------------------
interface alu_unit_if;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  AluOp;
   logic [31:0] X;
   logic        Zero;
   logic        Sign;

   modport master (
      output A,
      output B,
      output AluOp,
      input  X,
      input  Zero,
      input  Sign
   );

   modport slave (
      input  A,
      input  B,
      input  AluOp,
      output X,
      output Zero,
      output Sign
   );
endinterface : alu_unit_if

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
// 32-bit registered integer ALU for the ice-risc execute stage. On every rising
// clock edge the operands and opcode are sampled, one of sixteen operations is
// evaluated, and the result is registered together with its Zero and Sign
// flags. One cycle of latency, a new operation may be issued every cycle, no
// handshake and no stall.
//
// Ports
//    clk     in   1   rising-edge clock
//    rst     in   1   asynchronous, active-high reset (X=0, Zero=1, Sign=0)
//    aluBus  slave modport of alu_unit_if
//                 A, B, AluOp in; X, Zero, Sign out (all outputs registered)
//
// Opcodes (AluOp)
//    0 ADD   1 SUB   2 AND   3 OR    4 XOR   5 NOR   6 SLL   7 SRL
//    8 SRA   9 SLT  10 SLTU 11 PASSA 12 PASSB 13 LUI  14 ROR  15 ROL
// Shifts and rotates use sh = B[4:0]; B[31:5] is ignored for them.
// -----------------------------------------------------------------------------
module alu_unit (
   input  logic       clk,
   input  logic       rst,
   alu_unit_if.slave  aluBus
);

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_NOR   = 4'd5,
      OP_SLL   = 4'd6,
      OP_SRL   = 4'd7,
      OP_SRA   = 4'd8,
      OP_SLT   = 4'd9,
      OP_SLTU  = 4'd10,
      OP_PASSA = 4'd11,
      OP_PASSB = 4'd12,
      OP_LUI   = 4'd13,
      OP_ROR   = 4'd14,
      OP_ROL   = 4'd15
   } aluOpE;

   // Rotate right. The complementary shift is 32 - sh computed in 6 bits, so
   // for sh = 0 it becomes a shift by 32, which yields zero and leaves A intact.
   function automatic logic [31:0] rotateRight(input logic [31:0] value,
                                               input logic [4:0]  amount);
      logic [5:0] backAmount;
      backAmount  = 6'd32 - {1'b0, amount};
      rotateRight = (value >> amount) | (value << backAmount);
   endfunction

   // Rotate left, same zero-amount handling as rotateRight.
   function automatic logic [31:0] rotateLeft(input logic [31:0] value,
                                              input logic [4:0]  amount);
      logic [5:0] backAmount;
      backAmount = 6'd32 - {1'b0, amount};
      rotateLeft = (value << amount) | (value >> backAmount);
   endfunction

   logic [4:0]  shAmt_s;
   aluOpE       aluOp_s;
   logic [31:0] resultNext_s;
   logic        zeroNext_s;
   logic        signNext_s;

   logic [31:0] x_r;
   logic        zero_r;
   logic        sign_r;

   assign shAmt_s = aluBus.B[4:0];
   assign aluOp_s = aluOpE'(aluBus.AluOp);

   // Next-result selection for the sixteen operations.
   always_comb begin
      resultNext_s = 32'h0000_0000;
      case (aluOp_s)
         OP_ADD:   resultNext_s = aluBus.A + aluBus.B;
         OP_SUB:   resultNext_s = aluBus.A - aluBus.B;
         OP_AND:   resultNext_s = aluBus.A & aluBus.B;
         OP_OR:    resultNext_s = aluBus.A | aluBus.B;
         OP_XOR:   resultNext_s = aluBus.A ^ aluBus.B;
         OP_NOR:   resultNext_s = ~(aluBus.A | aluBus.B);
         OP_SLL:   resultNext_s = aluBus.A << shAmt_s;
         OP_SRL:   resultNext_s = aluBus.A >> shAmt_s;
         OP_SRA:   resultNext_s = $unsigned($signed(aluBus.A) >>> shAmt_s);
         OP_SLT:   resultNext_s = {31'h0000_0000, ($signed(aluBus.A) < $signed(aluBus.B))};
         OP_SLTU:  resultNext_s = {31'h0000_0000, (aluBus.A < aluBus.B)};
         OP_PASSA: resultNext_s = aluBus.A;
         OP_PASSB: resultNext_s = aluBus.B;
         OP_LUI:   resultNext_s = {aluBus.B[15:0], 16'h0000};
         OP_ROR:   resultNext_s = rotateRight(aluBus.A, shAmt_s);
         OP_ROL:   resultNext_s = rotateLeft(aluBus.A, shAmt_s);
         default:  resultNext_s = 32'h0000_0000;
      endcase
   end

   // Flags come from the same next value that loads X, so the three registers
   // can never disagree.
   assign zeroNext_s = (resultNext_s == 32'h0000_0000);
   assign signNext_s = resultNext_s[31];

   // Result and flag registers; reset clears X and reports it as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_r    <= 32'h0000_0000;
         zero_r <= 1'b1;
         sign_r <= 1'b0;
      end else begin
         x_r    <= resultNext_s;
         zero_r <= zeroNext_s;
         sign_r <= signNext_s;
      end
   end

   assign aluBus.X    = x_r;
   assign aluBus.Zero = zero_r;
   assign aluBus.Sign = sign_r;

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_unit
// Directed-vector bench for alu_unit. Inputs are driven 1 time unit after a
// rising edge and outputs are sampled 1 time unit after the following edge.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_unit;

   logic clk;
   logic rst;
   int   checkCount;
   int   failCount;

   alu_unit_if aluBus ();

   alu_unit dut (
      .clk    (clk),
      .rst    (rst),
      .aluBus (aluBus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check, reports any mismatch.
   task automatic checkValue(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Checks X and the flags implied by the expected result.
   task automatic checkResult(input string tag, input logic [31:0] expected);
      checkValue({tag, ".X"}, aluBus.X, expected);
      checkValue({tag, ".Zero"}, {31'h0, aluBus.Zero}, {31'h0, (expected == 32'h0)});
      checkValue({tag, ".Sign"}, {31'h0, aluBus.Sign}, {31'h0, expected[31]});
   endtask

   // Drives one operation, waits one edge, checks the registered result.
   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag,
                        input logic [31:0] expected);
      aluBus.AluOp = op;
      aluBus.A     = a;
      aluBus.B     = b;
      @(posedge clk);
      #1;
      checkResult(tag, expected);
   endtask

   logic [31:0] sweepExp [16];

   initial begin
      checkCount = 0;
      failCount  = 0;
      rst          = 1'b1;
      aluBus.A     = 32'd1234;
      aluBus.B     = 32'd5678;
      aluBus.AluOp = 4'd0;

      // Reset state held across edges.
      repeat (2) @(posedge clk);
      #1;
      checkResult("reset_hold", 32'h0000_0000);

      // Release with ADD 1234 + 5678.
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkResult("release_add", 32'd6912);

      // Arithmetic.
      issue(4'd1, 32'd1234, 32'd5678, "sub_neg", 32'hFFFF_EEA4);
      issue(4'd1, 32'd1234, 32'd1234, "sub_eq", 32'h0000_0000);
      issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap", 32'h0000_0000);

      // Logic.
      issue(4'd2, 32'h8234_5671, 32'h8234_5555, "and", 32'h8234_5451);
      issue(4'd5, 32'h0000_0000, 32'h0000_0000, "nor_zero", 32'hFFFF_FFFF);
      issue(4'd3, 32'h00F0_0F00, 32'h0F00_00F0, "or", 32'h0FF0_0FF0);
      issue(4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, "xor", 32'hF0F0_0F0F);

      // Shifts and rotates.
      issue(4'd8, 32'h8234_5671, 32'h0000_0003, "sra3", 32'hF046_8ACE);
      issue(4'd7, 32'h8234_5671, 32'h0000_0003, "srl3", 32'h1046_8ACE);
      issue(4'd6, 32'd1234, 32'h0000_0003, "sll3", 32'd9872);
      issue(4'd14, 32'h0000_0001, 32'h0000_0001, "ror1", 32'h8000_0000);
      issue(4'd15, 32'h8000_0001, 32'h0000_0001, "rol1", 32'h0000_0003);
      issue(4'd7, 32'h8234_5671, 32'h0000_0023, "srl_b23", 32'h1046_8ACE);
      issue(4'd14, 32'h8234_5671, 32'h0000_0023, "ror_b23", 32'h3046_8ACE);
      issue(4'd8, 32'h8234_5671, 32'h0000_0020, "sra_sh0", 32'h8234_5671);
      issue(4'd15, 32'h8234_5671, 32'hFFFF_FFE0, "rol_sh0", 32'h8234_5671);

      // Compares.
      issue(4'd9, 32'h8234_5671, 32'h0000_0003, "slt_neg_pos", 32'h0000_0001);
      issue(4'd10, 32'h8234_5671, 32'h0000_0003, "sltu_big_small", 32'h0000_0000);
      issue(4'd9, 32'h8234_5671, 32'h8345_5555, "slt_negs", 32'h0000_0001);
      issue(4'd10, 32'h8234_5671, 32'h8345_5555, "sltu_negs", 32'h0000_0001);
      issue(4'd9, 32'h1234_5678, 32'h1234_5678, "slt_eq", 32'h0000_0000);
      issue(4'd10, 32'h1234_5678, 32'h1234_5678, "sltu_eq", 32'h0000_0000);
      issue(4'd9, 32'h8000_0000, 32'h7FFF_FFFF, "slt_minneg", 32'h0000_0001);
      issue(4'd9, 32'h8000_0000, 32'h8000_0000, "slt_minneg_eq", 32'h0000_0000);

      // Reset mid-stream with X nonzero: immediate, no edge needed.
      issue(4'd11, 32'hDEAD_BEEF, 32'h0, "passa_pre_rst", 32'hDEAD_BEEF);
      #3;
      rst = 1'b1;
      #1;
      checkResult("reset_async", 32'h0000_0000);
      @(posedge clk);
      #1;
      checkResult("reset_held_edge", 32'h0000_0000);
      aluBus.AluOp = 4'd0;
      aluBus.A     = 32'd1234;
      aluBus.B     = 32'd5678;
      rst          = 1'b0;
      @(posedge clk);
      #1;
      checkResult("release_add2", 32'd6912);

      // Sweep all opcodes back-to-back, A=0x82345671, B=0x00001234 (sh=20).
      sweepExp[0]  = 32'h8234_68A5;
      sweepExp[1]  = 32'h8234_443D;
      sweepExp[2]  = 32'h0000_1230;
      sweepExp[3]  = 32'h8234_5675;
      sweepExp[4]  = 32'h8234_4445;
      sweepExp[5]  = 32'h7DCB_A98A;
      sweepExp[6]  = 32'h6710_0000;
      sweepExp[7]  = 32'h0000_0823;
      sweepExp[8]  = 32'hFFFF_F823;
      sweepExp[9]  = 32'h0000_0001;
      sweepExp[10] = 32'h0000_0000;
      sweepExp[11] = 32'h8234_5671;
      sweepExp[12] = 32'h0000_1234;
      sweepExp[13] = 32'h1234_0000;
      sweepExp[14] = 32'h4567_1823;
      sweepExp[15] = 32'h6718_2345;
      aluBus.A = 32'h8234_5671;
      aluBus.B = 32'h0000_1234;
      for (int op = 0; op < 16; op++) begin
         aluBus.AluOp = op[3:0];
         #1;
         // Output must still show the previous result until the next edge.
         if (op > 0) begin
            checkValue($sformatf("sweep_hold%0d", op), aluBus.X, sweepExp[op - 1]);
         end else begin
            checkValue("sweep_hold0", aluBus.X, 32'd6912);
         end
         @(posedge clk);
         #1;
         checkResult($sformatf("sweep_op%0d", op), sweepExp[op]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule : tb_alu_unit
